// File: rtl/systolic_feeder_if.sv
`default_nettype none
// ============================================================================
// systolic_feeder_if : operand load, array feed and result handshake bundle
// Revision 1.0
// ============================================================================
interface systolic_feeder_if;
    logic         ld_en;
    logic         ld_sel;
    logic [3:0]   ld_addr;
    logic [7:0]   ld_data;
    logic         start;
    logic         busy;
    logic         arr_rst_n;
    logic [7:0]   feed_top0;
    logic [7:0]   feed_top1;
    logic [7:0]   feed_top2;
    logic [7:0]   feed_top3;
    logic [7:0]   feed_left0;
    logic [7:0]   feed_left1;
    logic [7:0]   feed_left2;
    logic [7:0]   feed_left3;
    logic         arr_done;
    logic [127:0] arr_out;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_data;
    logic         err;

    modport master (
        output ld_en, ld_sel, ld_addr, ld_data, start, arr_done, arr_out, res_ready,
        input  busy, arr_rst_n, feed_top0, feed_top1, feed_top2, feed_top3,
               feed_left0, feed_left1, feed_left2, feed_left3, res_valid, res_data, err
    );

    modport slave (
        input  ld_en, ld_sel, ld_addr, ld_data, start, arr_done, arr_out, res_ready,
        output busy, arr_rst_n, feed_top0, feed_top1, feed_top2, feed_top3,
               feed_left0, feed_left1, feed_left2, feed_left3, res_valid, res_data, err
    );
endinterface
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// systolic_feeder : stores 4x4 A/B operands, skews them into a systolic array
//                   and captures the array result behind a valid/ready handshake
// Revision 1.0
// ============================================================================
module systolic_feeder #(
    parameter int DONE_TIMEOUT = 15
) (
    input wire          clk,
    input wire          reset,
    systolic_feeder_if.slave bus
);
    localparam int CW = (DONE_TIMEOUT < 7) ? 3 : $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      a_q [16];
    logic [7:0]      a_d [16];
    logic [7:0]      b_q [16];
    logic [7:0]      b_d [16];
    logic [7:0]      left_q [4];
    logic [7:0]      left_d [4];
    logic [7:0]      top_q [4];
    logic [7:0]      top_d [4];
    logic            busy_q, busy_d;
    logic            arr_rst_n_q, arr_rst_n_d;
    logic            res_valid_q, res_valid_d;
    logic [127:0]    res_data_q, res_data_d;
    logic            err_q, err_d;
    logic            feeding;
    logic [CW-1:0]   t_next;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        err_d      = err_q;
        feeding    = 1'b0;
        t_next     = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.ld_en) begin
                    if (bus.ld_sel) b_d[bus.ld_addr] = bus.ld_data;
                    else            a_d[bus.ld_addr] = bus.ld_data;
                end
                if (bus.start) begin
                    state_d = S_FEED;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    feeding = 1'b1;
                end
            end
            S_FEED, S_WAIT: begin
                if (bus.arr_done) begin
                    res_data_d = bus.arr_out;
                    state_d    = S_HOLD;
                    cnt_d      = '0;
                end else if (cnt_q == CW'(DONE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // cnt doubles as the skew index t while feeding
                    if (state_q == S_FEED && cnt_q != CW'(6)) begin
                        feeding = 1'b1;
                        t_next  = cnt_q + 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_HOLD: begin
                if (bus.res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        arr_rst_n_d = (state_d == S_FEED) || (state_d == S_WAIT);
        res_valid_d = (state_d == S_HOLD);
        for (int i = 0; i < 4; i++) begin
            left_d[i] = '0;
            top_d[i]  = '0;
            if (feeding && (int'(t_next) - i) >= 0 && (int'(t_next) - i) <= 3) begin
                left_d[i] = a_d[i*4 + (int'(t_next) - i)];
                top_d[i]  = b_d[(int'(t_next) - i)*4 + i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            arr_rst_n_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int k = 0; k < 4; k++) begin
                left_q[k] <= '0;
                top_q[k]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            arr_rst_n_q <= arr_rst_n_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
            a_q         <= a_d;
            b_q         <= b_d;
            left_q      <= left_d;
            top_q       <= top_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.arr_rst_n  = arr_rst_n_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.err        = err_q;
    assign bus.feed_left0 = left_q[0];
    assign bus.feed_left1 = left_q[1];
    assign bus.feed_left2 = left_q[2];
    assign bus.feed_left3 = left_q[3];
    assign bus.feed_top0  = top_q[0];
    assign bus.feed_top1  = top_q[1];
    assign bus.feed_top2  = top_q[2];
    assign bus.feed_top3  = top_q[3];
endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// tb_systolic_feeder : randomized bench with a matrix-level reference model
// Revision 1.0
// ============================================================================
module tb_systolic_feeder;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    systolic_feeder_if bus();

    systolic_feeder #(.DONE_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] ma [4][4];
    logic [7:0] mb [4][4];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // C = A x B with 8-bit wraparound, packed row-major with C[0][0] in the MSBs
    function automatic logic [127:0] product();
        logic [127:0] c = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                logic [7:0] s = '0;
                for (int k = 0; k < 4; k++) s = s + ma[i][k] * mb[k][j];
                c[127-8*(4*i+j) -: 8] = s;
            end
        return c;
    endfunction

    function automatic logic [31:0] exp_left(input int t);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++)
            if (t - i >= 0 && t - i <= 3) r[31-8*i -: 8] = ma[i][t-i];
        return r;
    endfunction

    function automatic logic [31:0] exp_top(input int t);
        logic [31:0] r = '0;
        for (int j = 0; j < 4; j++)
            if (t - j >= 0 && t - j <= 3) r[31-8*j -: 8] = mb[t-j][j];
        return r;
    endfunction

    function automatic logic [31:0] obs_left();
        return {bus.feed_left0, bus.feed_left1, bus.feed_left2, bus.feed_left3};
    endfunction

    function automatic logic [31:0] obs_top();
        return {bus.feed_top0, bus.feed_top1, bus.feed_top2, bus.feed_top3};
    endfunction

    task automatic check_idle_outputs(input string tag, input logic exp_err);
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        check_eq({tag, "_arr_rst_n"}, bus.arr_rst_n, 1'b0);
        check_eq({tag, "_res_valid"}, bus.res_valid, 1'b0);
        check_eq({tag, "_err"}, bus.err, exp_err);
        check_eq({tag, "_left"}, obs_left(), 32'h0);
        check_eq({tag, "_top"}, obs_top(), 32'h0);
    endtask

    task automatic write_all();
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++) begin
                @(negedge clk);
                bus.ld_en   = 1'b1;
                bus.ld_sel  = s[0];
                bus.ld_addr = a[3:0];
                bus.ld_data = s ? mb[a/4][a%4] : ma[a/4][a%4];
            end
        @(negedge clk);
        bus.ld_en = 1'b0;
    endtask

    // done_at < 0 means arr_done never rises; junk pokes start/ld_en while busy
    task automatic run(input string tag, input int done_at, input int hold, input bit junk);
        logic [127:0] exp_c = product();
        bit           done  = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < TO && !done; k++) begin
            check_eq({tag, "_feed_busy"}, bus.busy, 1'b1);
            check_eq({tag, "_feed_arr_rst_n"}, bus.arr_rst_n, 1'b1);
            check_eq({tag, "_feed_valid"}, bus.res_valid, 1'b0);
            check_eq({tag, "_feed_err"}, bus.err, 1'b0);
            check_eq({tag, "_feed_left"}, obs_left(), exp_left(k));
            check_eq({tag, "_feed_top"}, obs_top(), exp_top(k));
            if (junk) begin
                bus.start   = $urandom_range(0, 1);
                bus.ld_en   = 1'b1;
                bus.ld_sel  = $urandom_range(0, 1);
                bus.ld_addr = 4'($urandom);
                bus.ld_data = 8'($urandom);
            end
            if (k == done_at) begin
                bus.arr_done = 1'b1;
                bus.arr_out  = exp_c;
                done         = 1'b1;
            end else begin
                bus.arr_out = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            bus.arr_done = 1'b0;
            bus.start    = 1'b0;
            bus.ld_en    = 1'b0;
        end
        if (!done) begin
            check_idle_outputs({tag, "_timeout"}, 1'b1);
            @(negedge clk);
            check_idle_outputs({tag, "_timeout_sticky"}, 1'b1);
        end else begin
            for (int h = 0; h <= hold; h++) begin
                check_eq({tag, "_hold_valid"}, bus.res_valid, 1'b1);
                check_eq({tag, "_hold_data"}, bus.res_data, exp_c);
                check_eq({tag, "_hold_busy"}, bus.busy, 1'b1);
                check_eq({tag, "_hold_arr_rst_n"}, bus.arr_rst_n, 1'b0);
                check_eq({tag, "_hold_left"}, obs_left(), 32'h0);
                bus.res_ready = (h == hold);
                if (junk && h != hold) begin
                    bus.start   = 1'b1;
                    bus.ld_en   = 1'b1;
                    bus.ld_addr = 4'($urandom);
                    bus.ld_data = 8'($urandom);
                end
                @(negedge clk);
                bus.res_ready = 1'b0;
                bus.start     = 1'b0;
                bus.ld_en     = 1'b0;
            end
            check_idle_outputs({tag, "_after"}, 1'b0);
        end
    endtask

    initial begin
        reset        = 1'b0;
        bus.ld_en    = 1'b0;
        bus.ld_sel   = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        bus.start    = 1'b0;
        bus.arr_done = 1'b0;
        bus.arr_out  = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 1'b0);
        check_eq("reset_res_data", bus.res_data, 128'h0);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("idle_ready_high", 1'b0);
        bus.res_ready = 1'b0;

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (i == j) ? 8'd1 : 8'd0;
                mb[i][j] = 8'(4*i + j + 1);
            end
        write_all();
        run("ident_a", 9, 3, 1'b0);

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) mb[i][j] = (i == j) ? 8'd1 : 8'd0;
        write_all();
        run("ident_ab", 7, 0, 1'b0);

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 8'd2;
                mb[i][j] = 8'd2;
            end
        write_all();
        run("all_two", 12, 5, 1'b1);

        run("timeout", -1, 0, 1'b0);
        run("post_timeout", 10, 1, 1'b0);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    ma[i][j] = 8'($urandom);
                    mb[i][j] = 8'($urandom);
                end
            write_all();
            run("random", $urandom_range(0, TO - 1), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midfeed_busy", bus.busy, 1'b1);
        reset = 1'b0;
        #1;
        check_idle_outputs("midfeed_reset", 1'b0);
        check_eq("midfeed_reset_res_data", bus.res_data, 128'h0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 8'd0;
                mb[i][j] = 8'd0;
            end
        @(negedge clk);
        reset = 1'b1;
        run("after_reset", 5, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter: DONE_TIMEOUT, default 15, max cycles from FEED entry to arr_done before abort.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 ld_en  in  1  operand write strobe.
REQ-005 ld_sel  in  1  0 = matrix A, 1 = matrix B.
REQ-006 ld_addr  in  4  element index, row*4+col.
REQ-007 ld_data  in  8  element value.
REQ-008 start  in  1  begin multiply; single-cycle pulse.
REQ-009 busy  out  1  high in FEED, WAIT, HOLD.
REQ-010 arr_rst_n  out  1  active-low reset driven to the array.
REQ-011 feed_top0..feed_top3  out  8 each  column streams into the array top edge (B operand).
REQ-012 feed_left0..feed_left3  out  8 each  row streams into the array left edge (A operand).
REQ-013 arr_done  in  1  array completion flag.
REQ-014 arr_out  in  128  array result, C[i][j] at bits [127-8*(4i+j) -: 8].
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  consumer accepts result.
REQ-017 res_data  out  128  captured result, same packing as arr_out.
REQ-018 err  out  1  timeout flag.

Function
REQ-019 States: IDLE, FEED, WAIT, HOLD; all outputs registered.
REQ-020 ld_en in IDLE writes ld_data to A[ld_addr] (ld_sel=0) or B[ld_addr] (ld_sel=1) at the clock edge; ld_en outside IDLE is ignored.
REQ-021 start in IDLE: next cycle enters FEED with t=0, arr_rst_n=1, err cleared; start outside IDLE is ignored.
REQ-022 FEED cycle t (0..6): feed_left_i = A[i][t-i] if 0<=t-i<=3, else 0; feed_top_j = B[t-j][j] if 0<=t-j<=3, else 0.
REQ-023 After t=6, WAIT: all feed outputs 0, arr_rst_n held 1.
REQ-024 arr_done=1 in FEED or WAIT: arr_out captured into res_data that edge; next cycle HOLD, res_valid=1, arr_rst_n=0.
REQ-025 HOLD: res_data stable, res_valid held until res_valid&&res_ready; that edge returns to IDLE, res_valid=0.
REQ-026 res_ready with res_valid low has no effect.
REQ-027 Timeout counter starts at 0 on FEED entry, increments each cycle in FEED/WAIT; reaching DONE_TIMEOUT without arr_done: err=1, arr_rst_n=0, return to IDLE, no res_valid.
REQ-028 err is sticky until the next accepted start or reset.
REQ-029 In IDLE, arr_rst_n=0 and all feed outputs 0.
REQ-030 Arithmetic is done by the array; result elements are the array's 8-bit values (mod 256), passed through unchanged.

Reset
REQ-031 reset low at any time, including mid-FEED/WAIT/HOLD: state IDLE, busy=0, arr_rst_n=0, feed outputs 0, res_valid=0, res_data=0, err=0, counters 0, A and B all 0.
REQ-032 First start after reset release is accepted normally.

Verification
REQ-033 A=identity, B[k][j]=4k+j+1, start, model array -> res_data = 0x0102...10 (B packed), res_valid until res_ready.
REQ-034 A=I, B=I, start -> feed_left0..3 = 1 at t=0,2,4,6 respectively (1 at t=2i), 0 elsewhere; feed_top same pattern.
REQ-035 All A,B = 2 -> every C element 16, res_data = 0x10 repeated 16 times.
REQ-036 res_ready held 0 for 5 cycles in HOLD -> res_data/res_valid stable; start and ld_en during busy change nothing.
REQ-037 arr_done tied 0 -> err=1 after DONE_TIMEOUT=15 cycles in FEED/WAIT, back to IDLE, res_valid never 1; next start clears err.
REQ-038 reset asserted at FEED t=3 -> all outputs at reset values immediately; A/B read back as 0 via a following run (res_data=0).
